// File: rtl/cache_pkg.sv
// cache_pkg: shared state type and block geometry for the cache fill engine
package cache_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W = 4;
    localparam int WORD_BYTES = 2;
endpackage

// File: rtl/cache_fill_counter.sv
// cache_fill_counter: 4-bit word counter that stops at the block size
module cache_fill_counter
    import cache_pkg::*;
#(
    parameter int LIMIT = WORDS_PER_BLOCK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       increment,
    output logic [3:0] count,
    output logic       done
);
    // count up to LIMIT and hold there; clear takes priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clear) count <= '0;
        else if (increment && !done) count <= count + 4'd1;
    end
    assign done = count == 4'(LIMIT);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing cache block word by word and writes it into the arrays
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_req_en,
    output logic [ADDR_W-1:0] mem_req_addr
);
    localparam logic [3:0] LAST = 4'(WORDS_PER_BLOCK - 1);
    state_t state;
    logic [ADDR_W-1:0] base;
    logic [3:0] issue_cnt, recv_cnt;
    logic issue_done, recv_done;
    assign mem_req_en       = state == ISSUE && !issue_done;
    assign mem_req_addr     = mem_req_en ? base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES) : '0;
    assign write_data_array = state != IDLE && memory_data_valid && !recv_done;
    assign memory_address   = write_data_array ? base + ADDR_W'(recv_cnt) * ADDR_W'(WORD_BYTES) : '0;
    assign write_tag_array  = write_data_array && recv_cnt == LAST;
    cache_fill_counter #(.LIMIT(WORDS_PER_BLOCK)) issue_counter (
        .clk(clk), .rst(rst), .clear(state == IDLE), .increment(mem_req_en),
        .count(issue_cnt), .done(issue_done)
    );
    cache_fill_counter #(.LIMIT(WORDS_PER_BLOCK)) recv_counter (
        .clk(clk), .rst(rst), .clear(state == IDLE), .increment(write_data_array),
        .count(recv_cnt), .done(recv_done)
    );
    // state, busy flag and block base advance together; the final word write ends the fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fsm_busy <= 1'b0;
            base <= '0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                state <= ISSUE;
                fsm_busy <= 1'b1;
                base <= miss_address & ~ADDR_W'((1 << OFFSET_W) - 1);
            end
        end else if (write_tag_array) begin
            state <= IDLE;
            fsm_busy <= 1'b0;
        end else if (state == ISSUE && issue_cnt == LAST) begin
            state <= DRAIN;
        end
    end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter WORDS_PER_BLOCK, 8, 16-bit words per cache block (16-byte block).
REQ-002 SHALL have parameter ADDR_W, 16, byte-address width.
REQ-003 SHALL have one clock and asynchronous active-low reset; ports named clk and rst as in the cache.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 miss_detected  input  1  cache miss is pending this cycle.
REQ-007 miss_address  input  16  byte address of the missing access.
REQ-008 memory_data_valid  input  1  main memory returns one word this cycle, in request order.
REQ-009 fsm_busy  output  1  fill in progress; cache selects memory_address over the CPU address.
REQ-010 write_data_array  output  1  write the current returned word into the cache data array.
REQ-011 write_tag_array  output  1  write tag/valid for the block; pulses with the final data write.
REQ-012 memory_address  output  16  cache-side address of the word being written this cycle.
REQ-013 mem_req_en  output  1  issue one read request to main memory.
REQ-014 mem_req_addr  output  16  byte address of the read request.

Function
REQ-015 SHALL latch block base = {miss_address[15:4], 4'b0} when leaving IDLE.
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN; encoding free.
REQ-017 IDLE -> ISSUE on miss_detected; otherwise stay in IDLE.
REQ-018 ISSUE: assert mem_req_en each cycle, mem_req_addr = base + 2*issue_cnt; issue_cnt increments 0..7.
REQ-019 ISSUE -> DRAIN after the request with issue_cnt=7; recv_cnt<8 remains.
REQ-020 In ISSUE or DRAIN, memory_data_valid SHALL assert write_data_array the same cycle (combinational), with memory_address = base + 2*recv_cnt; recv_cnt then increments.
REQ-021 write_tag_array SHALL assert only in the cycle where memory_data_valid arrives with recv_cnt=7.
REQ-022 After that cycle the state SHALL return to IDLE; fsm_busy deasserts the following cycle.
REQ-023 fsm_busy SHALL be registered: high exactly while state is ISSUE or DRAIN.
REQ-024 Counters are 4-bit, saturate at 8, never wrap; address arithmetic is 16-bit modulo.
REQ-025 miss_detected while busy SHALL be ignored; no re-latch of base.
REQ-026 memory_data_valid in IDLE, or with recv_cnt=8, SHALL be ignored: no writes, no counter change.
REQ-027 Simultaneous issue and receive in ISSUE SHALL both take effect in the same cycle.
REQ-028 miss_detected in the same cycle busy falls SHALL start a new fill (IDLE sampled).
REQ-029 mem_req_en, write_data_array, write_tag_array SHALL be low whenever state is IDLE.

Reset
REQ-030 rst low SHALL immediately force state IDLE, issue_cnt=0, recv_cnt=0, base=0.
REQ-031 During and after reset: fsm_busy=0, write_data_array=0, write_tag_array=0, mem_req_en=0, mem_req_addr=0, memory_address=0.
REQ-032 Reset mid-fill SHALL abandon the fill; late memory_data_valid after reset SHALL cause no write.

Structure
REQ-033 Package cache_pkg SHALL hold the state typedef, WORDS_PER_BLOCK, block-offset width (4) and word size (2 bytes).
REQ-034 A 4-bit saturating counter sub-module cache_fill_counter (clear, increment, count, done) SHALL be instantiated twice (issue, receive).
REQ-035 No memory-latency parameter inside this block; latency is tolerated via memory_data_valid.

Verification
REQ-036 miss_address=0x1236 at cycle 0, 4-cycle memory -> mem_req_addr 0x1230..0x123E cycles 1-8; writes at 0x1230..0x123E cycles 5-12; write_tag_array only cycle 12; fsm_busy high cycles 1-12.
REQ-037 miss_address=0xFFF0 -> last request 0xFFFE, no address overflow beyond 16 bits, tag write once.
REQ-038 miss_detected held high during fill with miss_address changing to 0x4000 -> all addresses remain in block 0x1230.
REQ-039 rst low at cycle 6 of REQ-036 fill -> all outputs 0 at once; valids at cycles 7-12 produce no write; next miss restarts at word 0.
REQ-040 Memory with gapped valids (one cycle gap between words) -> 8 writes in order, DRAIN entered, write_tag_array with 8th word only.
REQ-041 memory_data_valid pulsed in IDLE -> write_data_array stays 0, counters unchanged.
